pma_checker: RTL and testbench

//  Runtime-programmable physical-memory-attribute checker. Replaces the fixed PMA table with NUM_REGIONS

---
 rtl/pma_checker.sv | 243 ++++++++++++++++++++++++
 tb/tb_pma_checker.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_checker.sv
// ----------------------------------------------------------------------------
// pma_checker
//
// Runtime-programmable physical-memory-attribute checker. A table of
// NUM_REGIONS software-writable regions is held, each with a base, a mask
// (1 = don't-care bit), an attribute byte and a lock bit. Up to NUM_CH
// independent lookup channels each get a registered one-cycle response.
// The first access fault is captured for trap and debug reporting.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cfg_we_i             config write strobe
//   cfg_idx_i            region index
//   cfg_sel_i            0=base 1=mask 2=attr 3=reserved
//   cfg_wdata_i          config write data
//   cfg_rdata_o          combinational read of the selected word
//   cfg_err_o            one-cycle pulse when a config write is rejected
//   req_valid_i          per-channel lookup request
//   req_addr_i           per-channel address, channel c at [c*XLEN +: XLEN]
//   req_acc_i            per-channel access type 0=r 1=w 2=x 3=illegal
//   rsp_valid_o          response valid, one cycle after the request
//   rsp_uncached_o       bypass cache
//   rsp_memregion_o      hit an enabled memory region
//   rsp_allow_o          access permitted
//   fault_valid_o        sticky fault record valid
//   fault_addr_o         faulting address
//   fault_ch_o           faulting channel
//   fault_acc_o          faulting access type
//   fault_clr_i          clear the fault record
//
// Attribute byte: [0]r [1]w [2]x [3]uncached [4]memregion [5]enable [7]lock.
// ----------------------------------------------------------------------------
module pma_checker #(
    parameter int              XLEN        = 32,
    parameter int              NUM_REGIONS = 16,
    parameter int              NUM_CH      = 2,
    parameter logic [XLEN-1:0] DEF_BASE    = 32'h8000_0000,
    parameter logic [XLEN-1:0] DEF_MASK    = 32'h7FFF_FFFF,
    localparam int             IDXW        = $clog2(NUM_REGIONS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [IDXW-1:0]      cfg_idx_i,
    input  logic [1:0]           cfg_sel_i,
    input  logic [XLEN-1:0]      cfg_wdata_i,
    output logic [XLEN-1:0]      cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic [NUM_CH-1:0]    req_valid_i,
    input  logic [NUM_CH*XLEN-1:0] req_addr_i,
    input  logic [NUM_CH*2-1:0]  req_acc_i,
    output logic [NUM_CH-1:0]    rsp_valid_o,
    output logic [NUM_CH-1:0]    rsp_uncached_o,
    output logic [NUM_CH-1:0]    rsp_memregion_o,
    output logic [NUM_CH-1:0]    rsp_allow_o,
    output logic                 fault_valid_o,
    output logic [XLEN-1:0]      fault_addr_o,
    output logic [1:0]           fault_ch_o,
    output logic [1:0]           fault_acc_o,
    input  logic                 fault_clr_i
);

    localparam logic [IDXW:0] NR = (IDXW+1)'(NUM_REGIONS);

    logic [XLEN-1:0]        base_reg [NUM_REGIONS];
    logic [XLEN-1:0]        mask_reg [NUM_REGIONS];
    logic [7:0]             attr_reg [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] region_we;

    logic                   idx_valid;
    logic                   target_locked;
    logic                   cfg_err_next;
    logic                   cfg_err_reg;

    // ---------------------------------------------------------------- config
    // Read mux and lock lookup scan all regions so an out-of-range index
    // simply matches nothing and reads as zero.
    always_comb begin
        idx_valid     = ({1'b0, cfg_idx_i} < NR);
        target_locked = 1'b0;
        cfg_rdata_o   = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (cfg_idx_i == IDXW'(r)) begin
                target_locked = attr_reg[r][7];
                case (cfg_sel_i)
                    2'd0:    cfg_rdata_o = base_reg[r];
                    2'd1:    cfg_rdata_o = mask_reg[r];
                    2'd2:    cfg_rdata_o = {{(XLEN-8){1'b0}}, attr_reg[r]};
                    default: cfg_rdata_o = '0;
                endcase
            end
        end
    end

    assign cfg_err_next = cfg_we_i && (!idx_valid || (cfg_sel_i == 2'd3) || target_locked);

    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        localparam logic [XLEN-1:0] RST_BASE = (gi == 0) ? DEF_BASE : '0;
        localparam logic [XLEN-1:0] RST_MASK = (gi == 0) ? DEF_MASK : '0;
        localparam logic [7:0]      RST_ATTR = (gi == 0) ? 8'h37    : 8'h00;

        // The lock bit also protects the region's own base and mask.
        assign region_we[gi] = cfg_we_i && (cfg_sel_i != 2'd3)
                            && (cfg_idx_i == IDXW'(gi)) && !attr_reg[gi][7];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                base_reg[gi] <= RST_BASE;
                mask_reg[gi] <= RST_MASK;
                attr_reg[gi] <= RST_ATTR;
            end else if (region_we[gi]) begin
                case (cfg_sel_i)
                    2'd0:    base_reg[gi] <= cfg_wdata_i;
                    2'd1:    mask_reg[gi] <= cfg_wdata_i;
                    default: attr_reg[gi] <= cfg_wdata_i[7:0] & 8'hBF; // bit 6 unimplemented
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- lookup
    logic [NUM_CH-1:0] uncached_next;
    logic [NUM_CH-1:0] memregion_next;
    logic [NUM_CH-1:0] allow_next;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [XLEN-1:0] addr;
        logic [1:0]      acc;
        logic            hit;
        logic [7:0]      hit_attr;
        logic            perm;

        assign addr = req_addr_i[gi*XLEN +: XLEN];
        assign acc  = req_acc_i[gi*2 +: 2];

        // Scan from the top down so the lowest matching region is the
        // last assignment and therefore wins.
        always_comb begin
            hit      = 1'b0;
            hit_attr = 8'h00;
            for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
                if (attr_reg[r][5] &&
                    ((addr & ~mask_reg[r]) == (base_reg[r] & ~mask_reg[r]))) begin
                    hit      = 1'b1;
                    hit_attr = attr_reg[r];
                end
            end
        end

        always_comb begin
            case (acc)
                2'd0:    perm = hit_attr[0];
                2'd1:    perm = hit_attr[1];
                2'd2:    perm = hit_attr[2];
                default: perm = 1'b0;
            endcase
        end

        // Gated by req_valid so idle responses register as all-zero.
        assign uncached_next[gi]  = req_valid_i[gi] && (hit ? hit_attr[3] : 1'b1);
        assign memregion_next[gi] = req_valid_i[gi] && hit && hit_attr[4];
        assign allow_next[gi]     = req_valid_i[gi] && hit && hit_attr[4] && perm;
    end

    logic [NUM_CH-1:0] rsp_valid_reg;
    logic [NUM_CH-1:0] rsp_uncached_reg;
    logic [NUM_CH-1:0] rsp_memregion_reg;
    logic [NUM_CH-1:0] rsp_allow_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_reg     <= '0;
            rsp_uncached_reg  <= '0;
            rsp_memregion_reg <= '0;
            rsp_allow_reg     <= '0;
            cfg_err_reg       <= 1'b0;
        end else begin
            rsp_valid_reg     <= req_valid_i;
            rsp_uncached_reg  <= uncached_next;
            rsp_memregion_reg <= memregion_next;
            rsp_allow_reg     <= allow_next;
            cfg_err_reg       <= cfg_err_next;
        end
    end

    assign rsp_valid_o     = rsp_valid_reg;
    assign rsp_uncached_o  = rsp_uncached_reg;
    assign rsp_memregion_o = rsp_memregion_reg;
    assign rsp_allow_o     = rsp_allow_reg;
    assign cfg_err_o       = cfg_err_reg;

    // ----------------------------------------------------------------- fault
    // The fault is computed from the same next-state values that load the
    // response registers, so the record becomes visible in the very cycle
    // the faulting response is driven.
    logic            fault_any;
    logic [1:0]      fault_ch_next;
    logic [XLEN-1:0] fault_addr_next;
    logic [1:0]      fault_acc_next;

    always_comb begin
        fault_any       = 1'b0;
        fault_ch_next   = 2'd0;
        fault_addr_next = '0;
        fault_acc_next  = 2'd0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (req_valid_i[c] && !allow_next[c]) begin
                fault_any       = 1'b1;
                fault_ch_next   = 2'(c);
                fault_addr_next = req_addr_i[c*XLEN +: XLEN];
                fault_acc_next  = req_acc_i[c*2 +: 2];
            end
        end
    end

    logic            fault_valid_reg;
    logic [XLEN-1:0] fault_addr_reg;
    logic [1:0]      fault_ch_reg;
    logic [1:0]      fault_acc_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_valid_reg <= 1'b0;
            fault_addr_reg  <= '0;
            fault_ch_reg    <= 2'd0;
            fault_acc_reg   <= 2'd0;
        end else if (fault_any && (!fault_valid_reg || fault_clr_i)) begin
            // A clear in the same cycle as a new fault yields to the fault.
            fault_valid_reg <= 1'b1;
            fault_addr_reg  <= fault_addr_next;
            fault_ch_reg    <= fault_ch_next;
            fault_acc_reg   <= fault_acc_next;
        end else if (fault_clr_i) begin
            fault_valid_reg <= 1'b0;
        end
    end

    assign fault_valid_o = fault_valid_reg;
    assign fault_addr_o  = fault_addr_reg;
    assign fault_ch_o    = fault_ch_reg;
    assign fault_acc_o   = fault_acc_reg;

endmodule

// File: tb/tb_pma_checker.sv
module tb_pma_checker;

    localparam int NR = 16;
    localparam int NC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cfg_err;
    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic [3:0]  req_acc;
    logic [1:0]  rsp_valid, rsp_uncached, rsp_memregion, rsp_allow;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic [1:0]  fault_ch, fault_acc;
    logic        fault_clr;

    int n_cmp = 0;
    int n_bad = 0;

    pma_checker dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_sel_i(cfg_sel),
        .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_acc_i(req_acc),
        .rsp_valid_o(rsp_valid), .rsp_uncached_o(rsp_uncached),
        .rsp_memregion_o(rsp_memregion), .rsp_allow_o(rsp_allow),
        .fault_valid_o(fault_valid), .fault_addr_o(fault_addr),
        .fault_ch_o(fault_ch), .fault_acc_o(fault_acc), .fault_clr_i(fault_clr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------ behavioural reference
    logic [31:0] m_base [NR];
    logic [31:0] m_mask [NR];
    logic [7:0]  m_attr [NR];
    logic [1:0]  e_valid, e_unc, e_mem, e_allow;
    logic        e_err;
    logic        mf_valid;
    logic [31:0] mf_addr;
    logic [1:0]  mf_ch, mf_acc;

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_base[r] = (r == 0) ? 32'h8000_0000 : 32'h0;
            m_mask[r] = (r == 0) ? 32'h7FFF_FFFF : 32'h0;
            m_attr[r] = (r == 0) ? 8'h37 : 8'h00;
        end
        {e_valid, e_unc, e_mem, e_allow, e_err} = '0;
        {mf_valid, mf_addr, mf_ch, mf_acc} = '0;
    endtask

    // First enabled region (in index order) whose unmasked bits agree.
    task automatic model_lookup(input logic [31:0] a, input logic [1:0] acc,
                                output logic unc, output logic mem, output logic alw);
        bit found = 0;
        unc = 1'b1; mem = 1'b0; alw = 1'b0;
        for (int r = 0; r < NR; r++) begin
            if (!found && m_attr[r][5] && (((a ^ m_base[r]) & ~m_mask[r]) == 32'h0)) begin
                found = 1;
                unc = m_attr[r][3];
                mem = m_attr[r][4];
                alw = m_attr[r][4] && (acc != 2'd3) && m_attr[r][acc];
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] idx, input logic [1:0] sel);
        case (sel)
            2'd0:    return m_base[idx];
            2'd1:    return m_mask[idx];
            2'd2:    return {24'h0, m_attr[idx]};
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock: predict from the pre-edge table, then update it.
    task automatic step();
        logic u, m, a;
        bit   got;
        got = 0;
        for (int c = 0; c < NC; c++) begin
            e_valid[c] = req_valid[c];
            if (req_valid[c]) begin
                model_lookup(req_addr[c*32 +: 32], req_acc[c*2 +: 2], u, m, a);
                e_unc[c] = u; e_mem[c] = m; e_allow[c] = a;
            end else begin
                e_unc[c] = 0; e_mem[c] = 0; e_allow[c] = 0;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (!got && e_valid[c] && !e_allow[c] && (!mf_valid || fault_clr)) begin
                got = 1;
                mf_addr = req_addr[c*32 +: 32];
                mf_ch   = 2'(c);
                mf_acc  = req_acc[c*2 +: 2];
            end
        end
        if (got) mf_valid = 1'b1;
        else if (fault_clr) mf_valid = 1'b0;
        e_err = cfg_we && ((cfg_sel == 2'd3) || m_attr[cfg_idx][7]);
        if (cfg_we && !e_err) begin
            case (cfg_sel)
                2'd0:    m_base[cfg_idx] = cfg_wdata;
                2'd1:    m_mask[cfg_idx] = cfg_wdata;
                default: m_attr[cfg_idx] = cfg_wdata[7:0] & 8'hBF;
            endcase
        end
        @(posedge clk);
        #1;
        cfg_we = 0; req_valid = 0; fault_clr = 0;
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_idx = 0; cfg_sel = 0; cfg_wdata = 0;
        req_valid = 0; req_addr = 0; req_acc = 0; fault_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [1:0] sel, input logic [31:0] d);
        cfg_we = 1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = d;
        step();
    endtask

    task automatic lookup(input int ch, input logic [31:0] a, input logic [1:0] acc);
        req_valid[ch] = 1'b1;
        req_addr[ch*32 +: 32] = a;
        req_acc[ch*2 +: 2] = acc;
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rsp_valid, rsp_uncached, rsp_memregion, rsp_allow, cfg_err,
             fault_valid, fault_addr, fault_ch, fault_acc} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rsp=%b fv=%b fa=%h err=%b want all zero",
                     {rsp_valid, rsp_uncached, rsp_memregion, rsp_allow}, fault_valid, fault_addr, cfg_err);
        end
        cfg_idx = 0; cfg_sel = 0; #1;
        n_cmp++; if (cfg_rdata !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_r0_base: got %h want 80000000", cfg_rdata); end
        cfg_sel = 1; #1;
        n_cmp++; if (cfg_rdata !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL reset_r0_mask: got %h want 7fffffff", cfg_rdata); end
        cfg_sel = 2; #1;
        n_cmp++; if (cfg_rdata !== 32'h37) begin n_bad++; $display("FAIL reset_r0_attr: got %h want 37", cfg_rdata); end
        cfg_idx = 5; cfg_sel = 1; #1;
        n_cmp++; if (cfg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_r5_mask: got %h want 0", cfg_rdata); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        lookup(0, 32'h8000_0100, 2'd0); step();
        n_cmp++;
        if ({rsp_valid[0], rsp_allow[0], rsp_memregion[0], rsp_uncached[0]} !== 4'b1110) begin
            n_bad++; $display("FAIL basic_hit: got v/a/m/u=%b want 1110",
                              {rsp_valid[0], rsp_allow[0], rsp_memregion[0], rsp_uncached[0]});
        end
        lookup(0, 32'h2000_0000, 2'd0); step();
        n_cmp++;
        if ({rsp_valid[0], rsp_allow[0], rsp_memregion[0], rsp_uncached[0]} !== 4'b1001) begin
            n_bad++; $display("FAIL basic_miss: got v/a/m/u=%b want 1001",
                              {rsp_valid[0], rsp_allow[0], rsp_memregion[0], rsp_uncached[0]});
        end
        n_cmp++;
        if ({fault_valid, fault_addr, fault_ch, fault_acc} !== {1'b1, 32'h2000_0000, 2'd0, 2'd0}) begin
            n_bad++; $display("FAIL basic_fault: got v=%b addr=%h ch=%0d acc=%0d want 1 20000000 0 0",
                              fault_valid, fault_addr, fault_ch, fault_acc);
        end
        fault_clr = 1; step();
        n_cmp++;
        if ({fault_valid, fault_addr, rsp_valid} !== {1'b0, 32'h2000_0000, 2'b00}) begin
            n_bad++; $display("FAIL basic_clear: got v=%b addr=%h rspv=%b want 0 20000000 00",
                              fault_valid, fault_addr, rsp_valid);
        end
        $display("test_basic done");
    endtask

    task automatic test_program();
        cfg_write(1, 0, 32'h2000_0000);
        cfg_write(1, 1, 32'h0000_0FFF);
        cfg_write(1, 2, 32'h0000_003B);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL program_err: got %b want 0", cfg_err); end
        lookup(1, 32'h2000_0004, 2'd2); step();
        n_cmp++;
        if ({rsp_valid[1], rsp_allow[1], rsp_uncached[1]} !== 3'b101) begin
            n_bad++; $display("FAIL program_exec: got v/a/u=%b want 101", {rsp_valid[1], rsp_allow[1], rsp_uncached[1]});
        end
        lookup(1, 32'h2000_0004, 2'd1); fault_clr = 1; step();
        n_cmp++;
        if ({rsp_valid[1], rsp_allow[1], rsp_memregion[1], fault_valid} !== 4'b1110) begin
            n_bad++; $display("FAIL program_write: got v/a/m/fv=%b want 1110",
                              {rsp_valid[1], rsp_allow[1], rsp_memregion[1], fault_valid});
        end
        $display("test_program done");
    endtask

    task automatic test_overlap();
        cfg_write(2, 0, 32'h8000_0000);
        cfg_write(2, 1, 32'h0000_0FFF);
        cfg_write(2, 2, 32'h0000_0039);
        lookup(0, 32'h8000_0010, 2'd1); step();
        n_cmp++;
        if ({rsp_valid[0], rsp_allow[0], rsp_uncached[0]} !== 3'b110) begin
            n_bad++; $display("FAIL overlap_r0_wins: got v/a/u=%b want 110", {rsp_valid[0], rsp_allow[0], rsp_uncached[0]});
        end
        $display("test_overlap done");
    endtask

    task automatic test_lock();
        cfg_write(3, 2, 32'h0000_00B3);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL lock_set_err: got %b want 0", cfg_err); end
        cfg_write(3, 0, 32'h1234_0000);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL lock_base_err: got %b want 1", cfg_err); end
        step();
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL lock_err_pulse: got %b want 0", cfg_err); end
        cfg_write(3, 2, 32'h0000_0000);
        cfg_idx = 3; cfg_sel = 0; #1;
        n_cmp++; if (cfg_rdata !== 32'h0) begin n_bad++; $display("FAIL lock_base_kept: got %h want 0", cfg_rdata); end
        cfg_sel = 2; #1;
        n_cmp++; if (cfg_rdata !== 32'hB3) begin n_bad++; $display("FAIL lock_attr_kept: got %h want b3", cfg_rdata); end
        cfg_write(4, 3, 32'hFFFF_FFFF);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL reserved_sel_err: got %b want 1", cfg_err); end
        // Reset while a response and a fault are in flight.
        lookup(0, 32'h0000_0000, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({rsp_valid, fault_valid, cfg_err} !== 4'b0) begin
            n_bad++; $display("FAIL midop_reset: got rspv=%b fv=%b err=%b want 0", rsp_valid, fault_valid, cfg_err);
        end
        do_reset();
        cfg_write(3, 0, 32'h1234_0000);
        cfg_idx = 3; cfg_sel = 0; #1;
        n_cmp++;
        if ({cfg_err, cfg_rdata} !== {1'b0, 32'h1234_0000}) begin
            n_bad++; $display("FAIL unlock_after_reset: got err=%b base=%h want 0 12340000", cfg_err, cfg_rdata);
        end
        $display("test_lock done");
    endtask

    task automatic test_fault_priority();
        lookup(0, 32'h0000_0000, 2'd0); lookup(1, 32'h0000_0001, 2'd2); step();
        n_cmp++;
        if ({fault_valid, fault_ch, fault_addr, fault_acc} !== {1'b1, 2'd0, 32'h0, 2'd0}) begin
            n_bad++; $display("FAIL fault_lowest_ch: got v=%b ch=%0d addr=%h acc=%0d want 1 0 00000000 0",
                              fault_valid, fault_ch, fault_addr, fault_acc);
        end
        lookup(1, 32'h0000_0008, 2'd1); step();
        n_cmp++;
        if (fault_addr !== 32'h0) begin n_bad++; $display("FAIL fault_sticky: got addr=%h want 00000000", fault_addr); end
        lookup(1, 32'h0000_0004, 2'd0); fault_clr = 1; step();
        n_cmp++;
        if ({fault_valid, fault_ch, fault_addr} !== {1'b1, 2'd1, 32'h4}) begin
            n_bad++; $display("FAIL fault_clr_and_new: got v=%b ch=%0d addr=%h want 1 1 00000004",
                              fault_valid, fault_ch, fault_addr);
        end
        fault_clr = 1; step();
        $display("test_fault_priority done");
    endtask

    task automatic test_same_cycle_cfg();
        cfg_we = 1; cfg_idx = 0; cfg_sel = 2; cfg_wdata = 32'h0;
        lookup(0, 32'h8000_0000, 2'd0); step();
        n_cmp++;
        if ({rsp_valid[0], rsp_allow[0]} !== 2'b11) begin
            n_bad++; $display("FAIL samecycle_old_table: got v/a=%b want 11", {rsp_valid[0], rsp_allow[0]});
        end
        lookup(0, 32'h8000_0000, 2'd0); step();
        n_cmp++;
        if ({rsp_valid[0], rsp_memregion[0], rsp_allow[0]} !== 3'b100) begin
            n_bad++; $display("FAIL samecycle_new_table: got v/m/a=%b want 100",
                              {rsp_valid[0], rsp_memregion[0], rsp_allow[0]});
        end
        fault_clr = 1; step();
        $display("test_same_cycle_cfg done");
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                cfg_we = 1; cfg_idx = 4'($urandom_range(0, 15)); cfg_sel = 2'($urandom_range(0, 3));
                case (cfg_sel)
                    2'd0:    cfg_wdata = $urandom;
                    2'd1:    cfg_wdata = (32'h1 << $urandom_range(0, 31)) - 32'h1;
                    default: cfg_wdata = 32'($urandom_range(0, 255)) & (($urandom_range(0, 7) == 0) ? 32'hFF : 32'h7F);
                endcase
            end
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 3) != 0) begin
                    r = 4'($urandom_range(0, 15));
                    a = ($urandom_range(0, 2) != 0) ? (m_base[r] ^ ($urandom & 32'h0000_1FFF)) : $urandom;
                    lookup(c, a, 2'($urandom_range(0, 3)));
                end
            end
            fault_clr = ($urandom_range(0, 4) == 0);
            step();
            n_cmp++;
            if ({rsp_valid, rsp_uncached, rsp_memregion, rsp_allow} !== {e_valid, e_unc, e_mem, e_allow}) begin
                n_bad++; $display("FAIL rand_rsp[%0d]: got v/u/m/a=%b want %b", i,
                                  {rsp_valid, rsp_uncached, rsp_memregion, rsp_allow}, {e_valid, e_unc, e_mem, e_allow});
            end
            n_cmp++;
            if ({fault_valid, fault_addr, fault_ch, fault_acc} !== {mf_valid, mf_addr, mf_ch, mf_acc}) begin
                n_bad++; $display("FAIL rand_fault[%0d]: got %b/%h/%0d/%0d want %b/%h/%0d/%0d", i,
                                  fault_valid, fault_addr, fault_ch, fault_acc, mf_valid, mf_addr, mf_ch, mf_acc);
            end
            n_cmp++;
            if (cfg_err !== e_err) begin n_bad++; $display("FAIL rand_cfg_err[%0d]: got %b want %b", i, cfg_err, e_err); end
            cfg_idx = 4'($urandom_range(0, 15)); cfg_sel = 2'($urandom_range(0, 3)); #1;
            n_cmp++;
            if (cfg_rdata !== model_read(cfg_idx, cfg_sel)) begin
                n_bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, cfg_rdata, model_read(cfg_idx, cfg_sel));
            end
        end
        $display("test_random done");
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        test_reset();
        test_basic();
        test_program();
        test_overlap();
        test_lock();
        test_fault_priority();
        test_same_cycle_cfg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
